ddr_wpack_buf: RTL and testbench

DDR_WPACK_BUF -- requirements
Module: ddr_wpack_buf

---
 rtl/ddr_wpack_buf_if.sv | 28 ++
 rtl/ddr_wpack_buf.sv | 167 ++++++++++++++++
 tb/tb_ddr_wpack_buf.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_wpack_buf_if.sv
// Bundle of the frame-control, beat-input and packed-word-output signals of ddr_wpack_buf.
// Handshakes: a transfer completes on a rising edge where valid and ready are both 1; valid never waits on ready.
interface ddr_wpack_buf_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 128,
    parameter int DEPTH = 16
);
    logic                     frame_load;
    logic                     frame_end;
    logic                     in_valid;
    logic                     in_ready;
    logic [IN_W-1:0]          in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [OUT_W-1:0]         out_data;
    logic [$clog2(DEPTH):0]   fill_cnt;
    logic                     overflow;

    modport master (
        output frame_load, frame_end, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, fill_cnt, overflow
    );

    modport slave (
        input  frame_load, frame_end, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, fill_cnt, overflow
    );
endinterface

// File: rtl/ddr_wpack_buf.sv
// Packs IN_W beats into OUT_W words and buffers them in a FWFT FIFO with a registered head.
// Macro WPACK_PARTIAL_FLUSH_EN: frame_end pads and pushes a partial word instead of discarding it.
module ddr_wpack_buf #(
    parameter int IN_W      = 16,
    parameter int OUT_W     = 128,
    parameter int DEPTH     = 16,
    parameter int MSB_FIRST = 1
) (
    input  logic                 ui_clk,
    input  logic                 rst_h,
    ddr_wpack_buf_if.slave       bus,
    output logic                 state_dbg_o
);
    localparam int RATIO  = OUT_W / IN_W;
    localparam int CNT_W  = $clog2(RATIO);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;

    typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [OUT_W-1:0]   shift_q, shift_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               ovf_q, ovf_d;
    logic [OUT_W-1:0]   head_q, head_d;
    logic [OUT_W-1:0]   mem [DEPTH];

    logic               full;
    logic               in_ready;
    logic               out_valid;
    logic               accept;
    logic               pop;
    logic               push;
    logic [OUT_W-1:0]   push_word;
    logic [OUT_W-1:0]   shifted;
    logic [PTR_W-1:0]   rd_nxt;
`ifdef WPACK_PARTIAL_FLUSH_EN
    logic [OUT_W-1:0]   padded;
    int unsigned        pad_bits;
`endif

    // in_ready depends on registered state only, so out_ready never reaches it combinationally.
    assign full      = (fill_q == FILL_W'(DEPTH));
    assign in_ready  = !rst_h && !full && (state_q == ST_RUN);
    assign out_valid = (fill_q != '0);
    assign accept    = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;
    assign rd_nxt    = rd_ptr_q + PTR_W'(1);

    always_comb begin
        shifted = '0;
        if (MSB_FIRST != 0) shifted = {shift_q[OUT_W-IN_W-1:0], bus.in_data};
        else                shifted = {bus.in_data, shift_q[OUT_W-1:IN_W]};
    end

`ifdef WPACK_PARTIAL_FLUSH_EN
    // Padding equals shifting in the missing zero beats all at once.
    always_comb begin
        pad_bits = (RATIO - int'(beat_cnt_q)) * IN_W;
        padded   = '0;
        if (MSB_FIRST != 0) padded = shift_q << pad_bits;
        else                padded = shift_q >> pad_bits;
    end
`endif

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        shift_d    = shift_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        ovf_d      = ovf_q;
        head_d     = head_q;
        push       = 1'b0;
        push_word  = shifted;

        if (bus.frame_load) begin
            state_d    = ST_RUN;
            beat_cnt_d = '0;
            shift_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fill_d     = '0;
            ovf_d      = 1'b0;
            head_d     = '0;
        end else begin
            if (bus.in_valid && !in_ready) ovf_d = 1'b1;

            case (state_q)
                ST_RUN: begin
                    if (accept) begin
                        shift_d = shifted;
                        if (beat_cnt_q == CNT_W'(RATIO - 1)) begin
                            push       = 1'b1;
                            beat_cnt_d = '0;
                        end else begin
                            beat_cnt_d = beat_cnt_q + CNT_W'(1);
                        end
                    end
                    if (bus.frame_end && (beat_cnt_d != '0)) state_d = ST_FLUSH;
                end
                ST_FLUSH: begin
`ifdef WPACK_PARTIAL_FLUSH_EN
                    if (!full) begin
                        push       = 1'b1;
                        push_word  = padded;
                        beat_cnt_d = '0;
                        shift_d    = '0;
                        state_d    = ST_RUN;
                    end
`else
                    beat_cnt_d = '0;
                    shift_d    = '0;
                    state_d    = ST_RUN;
`endif
                end
                default: state_d = ST_RUN;
            endcase

            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_nxt;
            if (push && !pop)      fill_d = fill_q + FILL_W'(1);
            else if (pop && !push) fill_d = fill_q - FILL_W'(1);

            // Head register tracks the oldest stored word: load on push into an emptying FIFO, else advance.
            if (push && ((fill_q == '0) || (pop && (fill_q == FILL_W'(1))))) head_d = push_word;
            else if (pop && (fill_q > FILL_W'(1)))                          head_d = mem[rd_nxt];
        end
    end

    always_ff @(posedge ui_clk or posedge rst_h) begin
        if (rst_h) begin
            state_q    <= ST_RUN;
            beat_cnt_q <= '0;
            shift_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            ovf_q      <= 1'b0;
            head_q     <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            ovf_q      <= ovf_d;
            head_q     <= head_d;
        end
    end

    always_ff @(posedge ui_clk) begin
        if (push) mem[wr_ptr_q] <= push_word;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = head_q;
    assign bus.fill_cnt  = fill_q;
    assign bus.overflow  = ovf_q;
    assign state_dbg_o   = (state_q == ST_FLUSH);
endmodule

// File: tb/tb_ddr_wpack_buf.sv
// Bench for ddr_wpack_buf: MSB-first and LSB-first instances share stimulus and a beat-list reference model.
module tb_ddr_wpack_buf;
    localparam int IN_W  = 16;
    localparam int OUT_W = 128;
    localparam int DEPTH = 16;
    localparam int RATIO = OUT_W / IN_W;
    localparam int FILL_W = $clog2(DEPTH) + 1;

    logic ui_clk = 1'b0;
    logic rst_h;
    logic st_m, st_l;

    always #5 ui_clk = ~ui_clk;

    ddr_wpack_buf_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) if_m ();
    ddr_wpack_buf_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) if_l ();

    ddr_wpack_buf #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .MSB_FIRST(1)) dut_m (
        .ui_clk(ui_clk), .rst_h(rst_h), .bus(if_m), .state_dbg_o(st_m)
    );
    ddr_wpack_buf #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .MSB_FIRST(0)) dut_l (
        .ui_clk(ui_clk), .rst_h(rst_h), .bus(if_l), .state_dbg_o(st_l)
    );

    // Reference model: stored words per layout, beats of the open word, flush pending, sticky overflow.
    logic [OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0] exp_l_q[$];
    logic [IN_W-1:0]  part_q[$];
    bit               m_flush;
    bit               m_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Beat i of a word sits in slot i counted from the MSB end (msb) or LSB end (lsb); missing beats are zero.
    function automatic logic [OUT_W-1:0] pack_word(input bit msb);
        logic [OUT_W-1:0] w;
        w = '0;
        for (int i = 0; i < part_q.size(); i++) begin
            if (msb) w[OUT_W-1-i*IN_W -: IN_W] = part_q[i];
            else     w[i*IN_W +: IN_W]         = part_q[i];
        end
        return w;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        exp_l_q.delete();
        part_q.delete();
        m_flush = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_step(input bit fl, input bit fe, input bit iv, input logic [IN_W-1:0] d, input bit ordy);
        bit full;
        bit rdy;
        if (fl) begin
            model_clear();
            return;
        end
        full = (exp_q.size() == DEPTH);
        rdy  = !full && !m_flush;
        if ((exp_q.size() > 0) && ordy) begin
            void'(exp_q.pop_front());
            void'(exp_l_q.pop_front());
        end
        if (iv && !rdy) m_ovf = 1'b1;
        if (m_flush) begin
`ifdef WPACK_PARTIAL_FLUSH_EN
            if (!full) begin
                exp_q.push_back(pack_word(1'b1));
                exp_l_q.push_back(pack_word(1'b0));
                part_q.delete();
                m_flush = 1'b0;
            end
`else
            part_q.delete();
            m_flush = 1'b0;
`endif
        end else begin
            if (iv && rdy) begin
                part_q.push_back(d);
                if (part_q.size() == RATIO) begin
                    exp_q.push_back(pack_word(1'b1));
                    exp_l_q.push_back(pack_word(1'b0));
                    part_q.delete();
                end
            end
            if (fe && (part_q.size() > 0)) m_flush = 1'b1;
        end
    endtask

    task automatic compare_outputs();
        bit exp_rdy;
        exp_rdy = (exp_q.size() < DEPTH) && !m_flush;
        check("m_in_ready",  OUT_W'(if_m.in_ready),  OUT_W'(exp_rdy));
        check("l_in_ready",  OUT_W'(if_l.in_ready),  OUT_W'(exp_rdy));
        check("m_out_valid", OUT_W'(if_m.out_valid), OUT_W'(exp_q.size() > 0));
        check("l_out_valid", OUT_W'(if_l.out_valid), OUT_W'(exp_q.size() > 0));
        check("m_fill_cnt",  OUT_W'(if_m.fill_cnt),  OUT_W'(exp_q.size()));
        check("l_fill_cnt",  OUT_W'(if_l.fill_cnt),  OUT_W'(exp_q.size()));
        check("m_overflow",  OUT_W'(if_m.overflow),  OUT_W'(m_ovf));
        check("l_overflow",  OUT_W'(if_l.overflow),  OUT_W'(m_ovf));
        check("m_state",     OUT_W'(st_m),           OUT_W'(m_flush));
        check("l_state",     OUT_W'(st_l),           OUT_W'(m_flush));
        if (exp_q.size() > 0) begin
            check("m_out_data", if_m.out_data, exp_q[0]);
            check("l_out_data", if_l.out_data, exp_l_q[0]);
        end
    endtask

    task automatic drive(input bit fl, input bit fe, input bit iv, input logic [IN_W-1:0] d, input bit ordy);
        if_m.frame_load = fl; if_l.frame_load = fl;
        if_m.frame_end  = fe; if_l.frame_end  = fe;
        if_m.in_valid   = iv; if_l.in_valid   = iv;
        if_m.in_data    = d;  if_l.in_data    = d;
        if_m.out_ready  = ordy; if_l.out_ready = ordy;
    endtask

    // Called just after a falling edge: drive, predict the next rising edge, then check at the next falling edge.
    task automatic cycle(input bit fl, input bit fe, input bit iv, input logic [IN_W-1:0] d, input bit ordy);
        drive(fl, fe, iv, d, ordy);
        model_step(fl, fe, iv, d, ordy);
        @(negedge ui_clk);
        compare_outputs();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_in_ready"},  OUT_W'(if_m.in_ready),  '0);
        check({tag, "_l_in_ready"},  OUT_W'(if_l.in_ready),  '0);
        check({tag, "_m_out_valid"}, OUT_W'(if_m.out_valid), '0);
        check({tag, "_m_fill_cnt"},  OUT_W'(if_m.fill_cnt),  '0);
        check({tag, "_m_overflow"},  OUT_W'(if_m.overflow),  '0);
        check({tag, "_m_out_data"},  if_m.out_data,          '0);
        check({tag, "_l_out_data"},  if_l.out_data,          '0);
        check({tag, "_m_state"},     OUT_W'(st_m),           '0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IN_W-1:0] d;
        bit fe, iv, ordy, fl;
        int ordy_pct;

        // Clock/reset
        rst_h = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        model_clear();
        #2;
        check_reset_outputs("por");
        repeat (3) @(negedge ui_clk);
        rst_h = 1'b0;
        #1;
        compare_outputs();

        // Eight ascending beats, drained immediately
        for (int i = 1; i <= RATIO; i++) cycle(1'b0, 1'b0, 1'b1, IN_W'(i), 1'b1);
        check("msb_word_valid", OUT_W'(if_m.out_valid), OUT_W'(1));
        check("msb_word", if_m.out_data, 128'h0001000200030004000500060007_0008);
        check("lsb_word", if_l.out_data, 128'h0008000700060005000400030002_0001);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);

        // Fill to full with output stalled, one beat too many, then frame_load
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < DEPTH * RATIO + 1; i++) cycle(1'b0, 1'b0, 1'b1, IN_W'($urandom), 1'b0);
        check("full_fill_cnt", OUT_W'(if_m.fill_cnt), OUT_W'(DEPTH));
        check("full_in_ready", OUT_W'(if_m.in_ready), '0);
        check("full_overflow", OUT_W'(if_m.overflow), OUT_W'(1));
        cycle(1'b1, 1'b1, 1'b1, 16'h1234, 1'b1);
        check("load_fill_cnt",  OUT_W'(if_m.fill_cnt),  '0);
        check("load_overflow",  OUT_W'(if_m.overflow),  '0);
        check("load_out_valid", OUT_W'(if_m.out_valid), '0);

        // Two-beat partial frame
        cycle(1'b0, 1'b0, 1'b1, 16'hAAAA, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 16'hBBBB, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
        check("flush_state", OUT_W'(st_m), OUT_W'(1));
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
        check("flush_state_done", OUT_W'(st_m), '0);
`ifdef WPACK_PARTIAL_FLUSH_EN
        check("flush_fill_cnt", OUT_W'(if_m.fill_cnt), OUT_W'(1));
        check("flush_msb_word", if_m.out_data, {16'hAAAA, 16'hBBBB, 96'h0});
        check("flush_lsb_word", if_l.out_data, {96'h0, 16'hBBBB, 16'hAAAA});
`else
        check("flush_fill_cnt", OUT_W'(if_m.fill_cnt), '0);
`endif

        // Near-full FIFO, three-beat partial word, frame_end with output stalled
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < (DEPTH - 1) * RATIO + 3; i++) cycle(1'b0, 1'b0, 1'b1, IN_W'($urandom), 1'b0);
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
`ifdef WPACK_PARTIAL_FLUSH_EN
        check("pad_full_fill_cnt", OUT_W'(if_m.fill_cnt), OUT_W'(DEPTH));
        check("pad_full_in_ready", OUT_W'(if_m.in_ready), '0);
`else
        check("pad_full_fill_cnt", OUT_W'(if_m.fill_cnt), OUT_W'(DEPTH - 1));
`endif
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);

        // Reset mid-word, then a fresh word of new beats only
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 16'hEE00 + IN_W'(i), 1'b0);
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        rst_h = 1'b1;
        #1;
        check_reset_outputs("midrst");
        model_clear();
        repeat (2) @(negedge ui_clk);
        rst_h = 1'b0;
        #1;
        compare_outputs();
        for (int i = 9; i <= 16; i++) cycle(1'b0, 1'b0, 1'b1, IN_W'(i), 1'b0);
        check("rst_msb_word", if_m.out_data, 128'h0009000a000b000c000d000e000f_0010);
        check("rst_lsb_word", if_l.out_data, 128'h0010000f000e000d000c000b000a_0009);

        // Randomized traffic with changing output back-pressure
        for (int i = 0; i < 3000; i++) begin
            if ((i % 500) == 0) ordy_pct = $urandom_range(10, 90);
            fl   = ($urandom_range(0, 299) == 0);
            fe   = ($urandom_range(0, 11) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 99) < ordy_pct);
            d    = IN_W'($urandom);
            cycle(fl, fe, iv, d, ordy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
